// File: rtl/uart_receive.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and a
// single-entry holding register with valid/ready, framing and overrun pulses.
module uart_receive #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sci_rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rx_s, rx_s_d;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             data_tick, stop_tick;

  // Idle-high line: synchronizer flops reset to 1 so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop take the pre-edge value of its
      // source, which is what builds the two-stage chain; blocking would collapse it.
      rx_meta <= sci_rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    data_tick = 1'b0;
    stop_tick = 1'b0;
    case (state)
      IDLE:  if (rx_s_d && !rx_s) state_nxt = START;
      START: if (cnt == HALF_LAST) state_nxt = rx_s ? IDLE : DATA;
      DATA: begin
        if (cnt == BIT_LAST) begin
          data_tick = 1'b1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          stop_tick = 1'b1;
          state_nxt = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= (state_nxt != IDLE);

      // Restart the bit timer on each state entry and after every data sample.
      if (state_nxt != state || data_tick) cnt <= '0;
      else                                 cnt <= cnt + 1'b1;

      if (data_tick) begin
        shreg[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 3'd1;
      end else if (state != DATA) begin
        bit_idx <= 3'd0;
      end

      // A consume in the delivery cycle frees the slot for the new byte.
      if (stop_tick && rx_s) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (stop_tick && !rx_s) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive: frames driven at 16 clk/bit, delivered bytes
// checked against a queue of expected values as the consumer accepts them.
module tb_uart_receive;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       sci_rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks    = 0;
  int n_errors    = 0;
  int cyc         = 0;
  int n_pop       = 0;
  int n_valid_cyc = 0;
  int n_ferr      = 0;
  int n_ovr       = 0;

  logic [7:0] exp_q[$];
  int         pop_cyc[$];

  uart_receive #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .sci_rx   (sci_rx),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every accepted byte is compared with the oldest expected one.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid)  n_valid_cyc++;
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $error("FAIL unexpected_byte: observed=0x%0h expected=none", rx_data);
        end else begin
          check("rx_byte", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        pop_cyc.push_back(cyc);
        n_pop++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_bit(input logic v);
    sci_rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Sends one frame; ready_at >= 0 pulses rx_ready for one cycle that many
  // cycles into the stop bit (10 lands on the stop-sample edge).
  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input logic push, input int ready_at);
    if (push) exp_q.push_back(b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (ready_at < 0) begin
      drive_bit(stop_val);
    end else begin
      sci_rx = stop_val;
      repeat (ready_at) @(posedge clk);
      #1 rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      repeat (CPB - 1 - ready_at) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"},   32'(rx_data),   32'h00);
    check({tag, "_rx_valid"},  32'(rx_valid),  32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check({tag, "_overrun"},   32'(overrun),   32'h0);
    check({tag, "_busy"},      32'(busy),      32'h0);
  endtask

  initial begin
    int p0, v0, f0, o0;

    rst = 1'b1; sci_rx = 1'b1; rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Single frame
    rx_ready = 1'b1;
    p0 = n_pop; v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovr;
    send_frame(8'h55, 1'b1, 1'b1, -1);
    repeat (4) @(posedge clk);
    #1;
    check("single_pops",         n_pop - p0,       1);
    check("single_valid_cycles", n_valid_cyc - v0, 1);
    check("single_no_ferr",      n_ferr - f0,      0);
    check("single_no_ovr",       n_ovr - o0,       0);
    check("single_valid_low",    32'(rx_valid),    32'h0);
    check("single_data_held",    32'(rx_data),     32'h55);

    // Back-to-back frames, no idle gap
    pop_cyc.delete();
    p0 = n_pop; f0 = n_ferr;
    send_frame(8'h00, 1'b1, 1'b1, -1);
    send_frame(8'hFF, 1'b1, 1'b1, -1);
    send_frame(8'hA5, 1'b1, 1'b1, -1);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_pops",    n_pop - p0,  3);
    check("b2b_no_ferr", n_ferr - f0, 0);
    if (pop_cyc.size() == 3) begin
      check("b2b_gap_1", pop_cyc[1] - pop_cyc[0], 160);
      check("b2b_gap_2", pop_cyc[2] - pop_cyc[1], 160);
    end

    // Overrun: second byte dropped while the first is held
    rx_ready = 1'b0;
    p0 = n_pop; o0 = n_ovr;
    send_frame(8'h3C, 1'b1, 1'b1, -1);
    send_frame(8'hC3, 1'b1, 1'b0, -1);
    repeat (4) @(posedge clk);
    #1;
    check("ovr_valid_held", 32'(rx_valid), 32'h1);
    check("ovr_data_kept",  32'(rx_data),  32'h3C);
    check("ovr_pulses",     n_ovr - o0,    1);
    check("ovr_no_pop",     n_pop - p0,    0);
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    check("ovr_consumed_valid", 32'(rx_valid), 32'h0);
    check("ovr_consumed_pop",   n_pop - p0,    1);

    // Consume and deliver on the same stop-sample edge
    p0 = n_pop; o0 = n_ovr;
    send_frame(8'h11, 1'b1, 1'b1, -1);
    send_frame(8'h22, 1'b1, 1'b1, 10);
    repeat (4) @(posedge clk);
    #1;
    check("simul_valid",  32'(rx_valid), 32'h1);
    check("simul_data",   32'(rx_data),  32'h22);
    check("simul_no_ovr", n_ovr - o0,    0);
    check("simul_pops",   n_pop - p0,    1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    check("simul_drain_pops", n_pop - p0, 2);

    // Framing error, then line held low for 40 cycles
    rx_ready = 1'b1;
    v0 = n_valid_cyc; f0 = n_ferr;
    send_frame(8'h81, 1'b0, 1'b0, -1);
    check("ferr_pulses",     n_ferr - f0,      1);
    check("ferr_no_valid",   n_valid_cyc - v0, 0);
    check("ferr_break_busy", 32'(busy),        32'h1);
    repeat (39) @(posedge clk);
    #1 sci_rx = 1'b1;
    @(posedge clk);
    #1;
    check("ferr_busy_until_high", 32'(busy), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("ferr_back_idle",   32'(busy),   32'h0);
    check("ferr_single_pulse", n_ferr - f0, 1);

    // Short low glitch is rejected at the start-bit sample
    v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovr;
    sci_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 sci_rx = 1'b1;
    check("glitch_busy", 32'(busy), 32'h1);
    repeat (10) @(posedge clk);
    #1;
    check("glitch_idle",     32'(busy),        32'h0);
    check("glitch_no_valid", n_valid_cyc - v0, 0);
    check("glitch_no_ferr",  n_ferr - f0,      0);
    check("glitch_no_ovr",   n_ovr - o0,       0);

    // Reset in the middle of a frame clears a held byte as well
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    check("pre_rst_valid", 32'(rx_valid), 32'h1);
    check("pre_rst_data",  32'(rx_data),  32'h5A);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h7E >> i));
    sci_rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(busy), 32'h0);
    rx_ready = 1'b1;
    p0 = n_pop; v0 = n_valid_cyc; f0 = n_ferr;
    send_frame(8'h99, 1'b1, 1'b1, -1);
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_pops",         n_pop - p0,       1);
    check("post_rst_valid_cycles", n_valid_cyc - v0, 1);
    check("post_rst_no_ferr",      n_ferr - f0,      0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_receive.md
# uart_receive

UART receiver that deserializes an 8N1 serial line into bytes. It is the downstream counterpart of the ROM-driven transmit path and consumes its `sci_tx` output, either looped back on-board or from an external link. Received bytes are presented through a single-entry holding register with a valid/ready handshake, and framing and overrun errors are flagged.

## Interface
- `CLKS_PER_BIT`, default 5208 (50 MHz / 9600 baud); `clk` cycles per bit; must be ≥ 4.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sci_rx`  in  1  asynchronous serial input; idle high.
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid` is also high.
- `rx_data`  out  8  received byte, stable while `rx_valid` is high.
- `rx_valid`  out  1  holding register full.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: byte dropped because the holding register was full.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Synchronizer: `sci_rx` → 2 flops → `rx_s`. `rx_s_d` is the 1-cycle delayed `rx_s`. All flops reset to 1.
- Counter `cnt`, width `$clog2(CLKS_PER_BIT)`, is cleared on every state entry. `bit_idx` is 3 bits. `shreg` is 8 bits.
- FSM states:
  - **IDLE**: on `rx_s_d==1 && rx_s==0`, go to START.
  - **START**: at `cnt == CLKS_PER_BIT/2 - 1` (integer division), sample `rx_s`. If 0, go to DATA with `bit_idx=0`. If 1, treat it as a glitch and go to IDLE with no flag.
  - **DATA**: at `cnt == CLKS_PER_BIT-1`, sample `rx_s` into `shreg[bit_idx]` (LSB first). If `bit_idx==7`, go to STOP; otherwise increment `bit_idx`.
  - **STOP**: at `cnt == CLKS_PER_BIT-1`, sample `rx_s`.
    - If 1, deliver the byte (see below) and go to IDLE.
    - If 0, pulse `frame_err`, discard the byte, and go to BREAK.
  - **BREAK**: wait for `rx_s==1`, then go to IDLE. This prevents a held-low line from retriggering.
- Delivery, evaluated in the stop-sample cycle:
  - Register empty, or `rx_valid && rx_ready` in the same cycle: `rx_data<=shreg` and `rx_valid<=1`.
  - Register full and no `rx_ready`: keep the old byte and pulse `overrun`.
- Consume: `rx_valid && rx_ready` with no simultaneous delivery clears `rx_valid` next cycle. `rx_data` holds its last value.
- `rx_ready` while `rx_valid==0` is ignored.
- Reset values: state IDLE, `rx_data=8'h00`, `rx_valid=0`, `frame_err=0`, `overrun=0`, `busy=0`, `cnt=0`, `bit_idx=0`, `shreg=0`.
- `rst` asserted mid-frame aborts the frame and clears the holding register; nothing is delivered. After release, the receiver needs a fresh falling edge.

## Timing
- Edge-detect latency: a `sci_rx` fall at cycle 0 appears on `rx_s` at cycle 2. START is entered at cycle 3.
- Start bit is sampled `CLKS_PER_BIT/2` cycles after START entry. Each data bit and the stop bit are sampled `CLKS_PER_BIT` cycles after the previous sample.
- `rx_valid` (or `frame_err` / `overrun`) is high on the cycle after the stop sample, about 3 + 9.5·`CLKS_PER_BIT` cycles after the start edge.
- Re-arm: the receiver is back in IDLE the cycle after the stop sample, half a bit before the nominal stop end. Back-to-back frames with no idle gap are received.
- `frame_err` and `overrun` are high for exactly one cycle per event.
- `busy` is registered from state.

## Test plan
(All with `CLKS_PER_BIT=16`; frames driven at exactly 16 cycles/bit.)
- **Single frame**: send 0x55, `rx_ready=1` → `rx_valid` high 1 cycle with `rx_data=8'h55`, no error pulses.
- **Back-to-back**: send 0x00, 0xFF, 0xA5 with no idle gap, `rx_ready=1` → three `rx_valid` pulses in order, spaced 160 cycles apart.
- **Overrun**: `rx_ready=0`, send 0x3C then 0xC3 → `rx_data` stays 0x3C with `rx_valid` held. One `overrun` pulse at the second stop sample. Raising `rx_ready` for 1 cycle then clears `rx_valid`.
- **Simultaneous consume/deliver**: hold 0x11, assert `rx_ready` exactly on the stop-sample cycle of 0x22 → `rx_valid` stays 1, `rx_data=8'h22`, no `overrun`.
- **Framing error and glitch**: send 0x81 with stop bit low, line low 40 more cycles → one `frame_err`, no `rx_valid`, `busy` until line high. A 4-cycle low glitch → no output, back to IDLE.
- **Reset mid-frame**: assert `rst` during bit 4 of 0x7E → all outputs at reset values next cycle. The next full frame, 0x99, is received correctly.
